rsa_operand_loader: RTL
=======================

# rsa_operand_loader

Upstream feeder for the RL modular-exponentiation core. It accepts a stream of 32-bit words over a valid/ready handshake and assembles the 2048-bit operands Message, PublicE and KeyN. It then issues a one-cycle START to RL and holds the operands stable until RL raises OE_N. It replaces the testbench-driven load path so that RL can be fed from a bus or DMA engine.

## Interface
- MAX_BIT, 2048, operand width in bits; must be a multiple of WORD_W
- WORD_W, 32, input word width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- abort  in  1  synchronous clear of the load sequence
- in_valid  in  1  in_data/in_mode valid
- in_data  in  WORD_W  operand word
- in_mode  in  1  mode bit; sampled with word 0 only
- in_ready  out  1  loader accepts a word this cycle
- START  out  1  one-cycle pulse to RL
- MODE  out  1  latched mode to RL
- Message  out  MAX_BIT  assembled M
- PublicE  out  MAX_BIT  assembled E
- KeyN  out  MAX_BIT  assembled N
- OE_N  in  1  RL completion (finish)
- busy  out  1  high in FIRE and WAIT
- err  out  1  operand check failure (see Configuration)

## Operation
- WORDS = MAX_BIT/WORD_W (64 at default). The sequence has 3*WORDS words in a fixed order: M, then E, then N. Each operand arrives least-significant word first.
- word_cnt runs from 0 to 3*WORDS-1 (8 bits at default).
  - A word is accepted when in_valid && in_ready.
  - Word k is written to operand k/WORDS, bit slice (k%WORDS)*WORD_W +: WORD_W.
- States:
  - LOAD: in_ready=1. Each accept increments word_cnt. On accepting word 3*WORDS-1: go to FIRE, or to ERR if the check fails. word_cnt returns to 0.
  - FIRE: START=1 for exactly this cycle. Next state is WAIT.
  - WAIT: in_ready=0. OE_N is sampled only in this state. When OE_N=1, go to LOAD next cycle.
  - ERR: err=1, in_ready=0, START never asserted. Left only by abort or reset.
- abort=1 in any state: next state is LOAD, word_cnt=0, err=0. Operand registers keep their contents. abort takes priority over OE_N and over a same-cycle accept; that word is dropped.
- Operand registers change only on an accept. They are stable from FIRE through the end of WAIT.
- MODE is latched on the accept of word 0. It is unchanged until the next word-0 accept.
- in_valid while in_ready=0: no accept and no state change. The source must hold the word.

## Timing
- Reset values: state=LOAD, word_cnt=0, in_ready=0 during the reset cycle, START=0, MODE=0, Message/PublicE/KeyN=0, busy=0, err=0.
- in_ready=1 from the first cycle after rst_n rises.
- Last word accepted in cycle t: START=1 in cycle t+1, with operands already valid in t+1. busy=1 from t+1.
- OE_N=1 in WAIT cycle u: busy=0 and in_ready=1 in cycle u+1.
- The minimum turnaround is one word per cycle. A full load takes 3*WORDS cycles of back-to-back accepts.
- rst_n low mid-load, or during WAIT: full reset next edge. The partial load is discarded and START is not issued.

## Configuration
- RSA_N_ODD_CHECK_EN:
  - Defined: after the last word, if KeyN[0]==0 (even modulus, invalid for Montgomery), the next state is ERR instead of FIRE. err is then held at 1.
  - Undefined: err is tied to 0, the ERR state does not exist, and the last word always leads to FIRE.

## Structure
- Shared package rsa_pkg: MAX_BIT, WORD_W, WORDS, and the state enum (LOAD, FIRE, WAIT, ERR). RL and the SRAM write-back path reuse the same constants.
- Single module, no sub-module. The operand write-enable decode (operand select, slice index) stays inline.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0 and in_ready=0. in_ready=1 one cycle after release.
- Back-to-back load:
  - Stimulus: 192 words with M=word index, E=0x10001 in word 64 and 0 elsewhere, N odd, in_mode=1.
  - Required response: START high exactly one cycle after the last accept; Message/PublicE/KeyN bit-exact; MODE=1.
- Back-pressure and gaps:
  - Stimulus: random in_valid gaps, plus a word presented during WAIT.
  - Required response: no drop or duplicate; the word is accepted only after OE_N=1 returns the loader to LOAD.
- Abort at word 100 (inside E):
  - Stimulus: abort at word 100, then a fresh 192-word load.
  - Required response: word_cnt restarts at 0; the first START follows only the fresh 192nd word.
- Even modulus with RSA_N_ODD_CHECK_EN:
  - Stimulus: KeyN[0]=0.
  - Required response: no START; err=1 held and in_ready=0; abort clears err and sets in_ready=1.
- Same load with the macro undefined -> START issued, err stays 0.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: operand geometry and loader state encoding.
// Shared by the operand loader, RL and the SRAM write-back path.
package rsa_pkg;

  localparam int MAX_BIT = 2048;
  localparam int WORD_W  = 32;
  localparam int WORDS   = MAX_BIT / WORD_W;

  typedef enum logic [1:0] {
    LOAD,
    FIRE,
    WAIT,
    ERR
  } state_t;

endpackage

// File: rtl/rsa_operand_loader.sv
// rsa_operand_loader: assembles M, E, N from a word stream and starts RL.
// Define RSA_N_ODD_CHECK_EN to reject even moduli via the ERR state.
module rsa_operand_loader #(
  parameter int MAX_BIT = rsa_pkg::MAX_BIT,
  parameter int WORD_W  = rsa_pkg::WORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_mode,
  output logic               in_ready,
  output logic               START,
  output logic               MODE,
  output logic [MAX_BIT-1:0] Message,
  output logic [MAX_BIT-1:0] PublicE,
  output logic [MAX_BIT-1:0] KeyN,
  input  logic               OE_N,
  output logic               busy,
  output logic               err
);

  import rsa_pkg::*;

  localparam int NW = MAX_BIT / WORD_W;
  localparam int CW = $clog2(3 * NW);
  localparam logic [CW-1:0] LAST = CW'(3 * NW - 1);
  localparam logic [CW-1:0] B1   = CW'(NW);
  localparam logic [CW-1:0] B2   = CW'(2 * NW);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] slice;
  logic [1:0]    sel;
  logic          accept;
  logic          last;
  logic          chk_fail;

  // in_ready is gated by rst_n so nothing is taken in the reset cycle
  assign in_ready = rst_n && (state == LOAD);
  assign accept   = in_valid && in_ready && !abort;
  assign last     = (word_cnt == LAST);
  assign START    = (state == FIRE);
  assign busy     = (state == FIRE) || (state == WAIT);

`ifdef RSA_N_ODD_CHECK_EN
  logic n_odd;

  // with a single word per operand, N[0] is still on the bus
  assign n_odd    = (NW == 1) ? in_data[0] : KeyN[0];
  assign chk_fail = !n_odd;
  assign err      = (state == ERR);
`else
  assign chk_fail = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    sel   = 2'd0;
    slice = word_cnt;
    unique case (1'b1)
      (word_cnt >= B2): begin
        sel   = 2'd2;
        slice = word_cnt - B2;
      end
      (word_cnt >= B1) && (word_cnt < B2): begin
        sel   = 2'd1;
        slice = word_cnt - B1;
      end
      (word_cnt < B1): begin
        sel   = 2'd0;
        slice = word_cnt;
      end
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      LOAD: if (accept && last) nxt = chk_fail ? ERR : FIRE;
      FIRE: nxt = WAIT;
      WAIT: if (OE_N) nxt = LOAD;
      ERR:  nxt = ERR;
    endcase
    if (abort) nxt = LOAD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      word_cnt <= '0;
      MODE     <= 1'b0;
    end else begin
      state <= nxt;
      if (abort) begin
        word_cnt <= '0;
      end else if (accept) begin
        word_cnt <= last ? '0 : word_cnt + 1'b1;
      end
      if (accept && (word_cnt == '0)) MODE <= in_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Message <= '0;
      PublicE <= '0;
      KeyN    <= '0;
    end else if (accept) begin
      unique case (sel)
        2'd0:    Message[slice*WORD_W +: WORD_W] <= in_data;
        2'd1:    PublicE[slice*WORD_W +: WORD_W] <= in_data;
        2'd2:    KeyN[slice*WORD_W +: WORD_W]    <= in_data;
        default: ;
      endcase
    end
  end

endmodule
